// File: rtl/matrix_op_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_op_sequencer : collects src1/op/src2/dest, runs the ALU under a watchdog, writes back. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module matrix_op_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       is_reg,
  input  logic [1:0] reg_num,
  input  logic       is_op,
  input  logic [2:0] op_code,
  input  logic       is_clear,
  input  logic       alu_done,
  output logic       alu_start,
  output logic       alu_abort,
  output logic [2:0] alu_op,
  output logic [1:0] rd_addr_a,
  output logic [1:0] rd_addr_b,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_OP_WAIT   = 3'd1;
  localparam logic [2:0] S_SRC2_WAIT = 3'd2;
  localparam logic [2:0] S_DEST_WAIT = 3'd3;
  localparam logic [2:0] S_START     = 3'd4;
  localparam logic [2:0] S_BUSY      = 3'd5;
  localparam logic [2:0] S_WRITE     = 3'd6;
  localparam logic [2:0] S_ERROR     = 3'd7;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [2:0]       state, state_nxt;
  logic [1:0]       src1, src2, dest;
  logic [2:0]       op;
  logic [CNT_W-1:0] cnt;

  // Strobe priority: clear beats op beats reg.
  logic op_v, reg_v, op_bin, op_tr, timeout;
  assign op_v    = is_op & ~is_clear;
  assign reg_v   = is_reg & ~is_clear & ~is_op;
  assign op_bin  = (op_code <= 3'd2);
  assign op_tr   = (op_code == 3'd3);
  assign timeout = (cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (is_clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (reg_v) state_nxt = S_OP_WAIT;
        S_OP_WAIT, S_SRC2_WAIT: begin
          if (op_v) begin
            if (op_tr)       state_nxt = S_DEST_WAIT;
            else if (op_bin) state_nxt = S_SRC2_WAIT;
            else             state_nxt = S_ERROR;
          end else if (reg_v && state == S_SRC2_WAIT) begin
            state_nxt = S_DEST_WAIT;
          end
        end
        S_DEST_WAIT: if (reg_v) state_nxt = S_START;
        S_START:     state_nxt = S_BUSY;
        S_BUSY: begin
          if (alu_done)     state_nxt = S_WRITE;
          else if (timeout) state_nxt = S_ERROR;
        end
        S_WRITE:     state_nxt = S_IDLE;
        default:     state_nxt = state;
      endcase
    end
  end

  always_comb begin
    alu_start = (state == S_START);
    alu_abort = (is_clear && (state == S_START || state == S_BUSY)) ||
                (!is_clear && state == S_BUSY && !alu_done && timeout);
    wr_en     = (state == S_WRITE);
    done      = (state == S_WRITE);
    err       = (state == S_ERROR);
    busy      = (state == S_START) || (state == S_BUSY) || (state == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      src1 <= 2'd0;
      src2 <= 2'd0;
      dest <= 2'd0;
      op   <= 3'd0;
      cnt  <= '0;
    end else if (is_clear) begin
      src1 <= 2'd0;
      src2 <= 2'd0;
      dest <= 2'd0;
      op   <= 3'd0;
    end else begin
      case (state)
        S_IDLE:      if (reg_v) src1 <= reg_num;
        S_OP_WAIT, S_SRC2_WAIT: begin
          if (reg_v) begin
            if (state == S_OP_WAIT) src1 <= reg_num;
            else                    src2 <= reg_num;
          end else if (op_v && op_bin) begin
            op <= op_code;
          end else if (op_v && op_tr) begin
            op   <= 3'd3;
            src2 <= 2'd0;
          end
        end
        S_DEST_WAIT: if (reg_v) dest <= reg_num;
        S_START:     cnt <= '0;
        S_BUSY:      if (!alu_done && !timeout) cnt <= cnt + C_ONE;
        default: ;
      endcase
    end
  end

  assign alu_op    = op;
  assign rd_addr_a = src1;
  assign rd_addr_b = src2;
  assign wr_addr   = dest;

endmodule

`default_nettype wire

// File: tb/tb_matrix_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matrix_op_sequencer : directed + random stimulus against a behavioural model. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_matrix_op_sequencer;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic       clk = 1'b0;
  logic       nrst, is_reg, is_op, is_clear, alu_done;
  logic [1:0] reg_num;
  logic [2:0] op_code;
  logic       alu_start, alu_abort, wr_en, busy, done, err;
  logic [2:0] alu_op;
  logic [1:0] rd_addr_a, rd_addr_b, wr_addr;

  always #5 clk = ~clk;

  matrix_op_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .is_reg(is_reg), .reg_num(reg_num), .is_op(is_op),
    .op_code(op_code), .is_clear(is_clear), .alu_done(alu_done),
    .alu_start(alu_start), .alu_abort(alu_abort), .alu_op(alu_op),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cycle, got, exp);
    end
  endtask

  // Model: which item the operator still owes, plus the operand values.
  typedef enum {P_IDLE, P_NEED_OP, P_NEED_B, P_NEED_D, P_GO, P_RUN, P_WB, P_FAULT} phase_t;
  phase_t m_ph;
  int     m_a, m_b, m_d, m_op, m_wait;

  task automatic model_reset();
    m_ph = P_IDLE; m_a = 0; m_b = 0; m_d = 0; m_op = 0; m_wait = 0;
  endtask

  task automatic cyc(input logic r, input logic [1:0] rn, input logic o, input logic [2:0] oc,
                     input logic c, input logic d, input logic rs);
    logic       e_start, e_abort, e_wr, e_err, e_busy, t_op, t_reg, expired;
    logic [14:0] exp_v, got_v;
    @(negedge clk);
    is_reg = r; reg_num = rn; is_op = o; op_code = oc; is_clear = c; alu_done = d; nrst = ~rs;
    #1;
    t_op    = o && !c;
    t_reg   = r && !c && !o;
    expired = (m_ph == P_RUN) && (m_wait + 1 == TIMEOUT);
    e_start = (m_ph == P_GO);
    e_abort = (c && (m_ph == P_GO || m_ph == P_RUN)) || (!c && !d && expired);
    e_wr    = (m_ph == P_WB);
    e_err   = (m_ph == P_FAULT);
    e_busy  = (m_ph == P_GO || m_ph == P_RUN || m_ph == P_WB);
    exp_v = {e_busy, e_start, e_abort, e_wr, e_wr, e_err, 3'(m_op), 2'(m_a), 2'(m_b), 2'(m_d)};
    got_v = {busy, alu_start, alu_abort, wr_en, done, err, alu_op, rd_addr_a, rd_addr_b, wr_addr};
    check("outs", 32'(got_v), 32'(exp_v));
    cycle++;
    if (rs) begin
      model_reset();
    end else if (c) begin
      m_ph = P_IDLE; m_a = 0; m_b = 0; m_d = 0; m_op = 0;
    end else begin
      case (m_ph)
        P_IDLE:   if (t_reg) begin m_a = rn; m_ph = P_NEED_OP; end
        P_NEED_OP, P_NEED_B: begin
          if (t_op) begin
            if (oc == 3)     begin m_op = 3; m_b = 0; m_ph = P_NEED_D; end
            else if (oc < 3) begin m_op = oc; m_ph = P_NEED_B; end
            else             m_ph = P_FAULT;
          end else if (t_reg) begin
            if (m_ph == P_NEED_OP) m_a = rn;
            else begin m_b = rn; m_ph = P_NEED_D; end
          end
        end
        P_NEED_D: if (t_reg) begin m_d = rn; m_ph = P_GO; end
        P_GO:     begin m_wait = 0; m_ph = P_RUN; end
        P_RUN: begin
          if (d)            m_ph = P_WB;
          else if (expired) m_ph = P_FAULT;
          else              m_wait++;
        end
        P_WB:     m_ph = P_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    nrst = 0; is_reg = 0; reg_num = 0; is_op = 0; op_code = 0; is_clear = 0; alu_done = 0;
    @(posedge clk);
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // binary op: src1=1, mult, src2=2, dest=3, done on 4th busy cycle
    cyc(1, 1, 0, 0, 0, 0, 0); cyc(0, 0, 1, 2, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0, 0); cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);                       // START ignores alu_done
    idle(3); cyc(0, 0, 0, 0, 0, 1, 0); idle(2);
    // transpose with reselect
    cyc(1, 0, 0, 0, 0, 0, 0); cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0, 0);
    idle(2); cyc(0, 0, 0, 0, 0, 1, 0); idle(2);
    // invalid op, ignored strobes, clear beats reg
    cyc(1, 1, 0, 0, 0, 0, 0); cyc(0, 0, 1, 5, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0, 0); cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(1, 3, 0, 0, 1, 0, 0); idle(1);
    // watchdog
    cyc(1, 2, 0, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0, 0);
    idle(8); cyc(0, 0, 0, 0, 1, 0, 0); idle(1);
    // clear during busy
    cyc(1, 3, 0, 0, 0, 0, 0); cyc(0, 0, 1, 3, 0, 0, 0); cyc(1, 2, 0, 0, 0, 0, 0);
    idle(2); cyc(0, 0, 0, 0, 1, 1, 0); idle(2);
    // reset in DEST_WAIT, then fresh select
    cyc(1, 1, 0, 0, 0, 0, 0); cyc(0, 0, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1); idle(1); cyc(1, 3, 0, 0, 0, 0, 0); idle(1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic       r, o, c, d, rs;
      logic [2:0] oc;
      r  = ($urandom_range(0, 99) < 35);
      o  = ($urandom_range(0, 99) < 20);
      c  = ($urandom_range(0, 99) < 4);
      d  = ($urandom_range(0, 99) < 25);
      rs = !c && ($urandom_range(0, 99) < 2);
      oc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      cyc(r, 2'($urandom_range(0, 3)), o, oc, c, d, rs);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
